data_manager_replay: RTL

//  Next-gen data manager with an internal replay buffer. Accepts a data stream from upstream,

---
 rtl/data_manager_pkg.sv | 41 ++++
 rtl/data_manager_ram.sv | 36 +++
 rtl/data_manager_replay.sv | 136 +++++++++++++
 3 files changed

// File: rtl/data_manager_pkg.sv
// Shared helpers for the replay data manager.
// Width helpers turn a buffer depth into the ID/pointer width and the count width.
// The pointer helpers do circular arithmetic modulo an arbitrary depth, so the ID space
// need not be a power of two. All helpers work on int unsigned values; callers cast
// the results back to their own widths.
package data_manager_pkg;

    // ID/pointer width for a buffer of 'depth' entries
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Count width able to hold 0..depth inclusive
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // (p + n) mod depth, valid for p < depth and n <= depth
    function automatic int unsigned ptr_add(input int unsigned p, input int unsigned n,
                                            input int unsigned depth);
        int unsigned s;
        s = p + n;
        return (s >= depth) ? s - depth : s;
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
        return ptr_add(p, 1, depth);
    endfunction

    // Circular distance from b forward to a
    function automatic int unsigned ptr_dist(input int unsigned a, input int unsigned b,
                                             input int unsigned depth);
        return (a >= b) ? a - b : a + depth - b;
    endfunction

    // An ID is meaningful only below depth (matters when depth is not a power of two)
    function automatic logic in_range(input int unsigned id, input int unsigned depth);
        return id < depth;
    endfunction

endpackage

// File: rtl/data_manager_ram.sv
// Replay buffer storage: DEPTH x DATA_WIDTH, one synchronous write port and one
// combinational read port.
// Ports:
//   clk    - clock, write on posedge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module data_manager_ram
    import data_manager_pkg::*;
#(
    parameter int DEPTH      = 7,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: a location is only read after it has been written
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_manager_replay.sv
// Data manager with replay buffer. Upstream beats are stored and tagged with a
// circular ID, issued downstream, held until retired by count, and replayed from the
// buffer after an abort rewinds the issue pointer.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both high at the
// rising clock edge; valid (in_valid / valid_o) must not depend on the same-cycle ready.
// A downstream issue is additionally void in any cycle with abort_vld high.
//
// Ports:
//   clk, reset         - clock; synchronous active-low reset
//   in_valid/in_ready  - upstream handshake, in_data payload
//   valid_o/ready_i    - downstream handshake, data_o payload, data_id its ID
//   retire_vld/_cnt    - retire the retire_cnt oldest outstanding beats
//   abort_vld/abort_id - discard issued beats from abort_id onward and replay them
//   outstanding_cnt    - issued but not retired
//   occupancy_cnt      - held in the buffer (unsent + outstanding)
//   err_o              - one-cycle pulse after an illegal retire or abort
module data_manager_replay
    import data_manager_pkg::*;
#(
    parameter  int DEPTH      = 7,
    parameter  int DATA_WIDTH = 32,
    localparam int PTR_W      = ptr_w(DEPTH),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [PTR_W-1:0]      data_id,
    input  logic                  retire_vld,
    input  logic [CNT_W-1:0]      retire_cnt,
    input  logic                  abort_vld,
    input  logic [PTR_W-1:0]      abort_id,
    output logic [CNT_W-1:0]      outstanding_cnt,
    output logic [CNT_W-1:0]      occupancy_cnt,
    output logic                  err_o
);

    logic [PTR_W-1:0] wr_ptr, send_ptr, ret_ptr;
    logic [CNT_W-1:0] out_cnt, occ_cnt;
    logic             err_q;

    logic             accept, issue;
    logic             ret_legal, abort_legal;
    logic [PTR_W-1:0] ret_a;
    logic [CNT_W-1:0] out_a, occ_a, abort_d;
    logic [PTR_W-1:0] wr_n, send_n;
    logic [CNT_W-1:0] out_n, occ_n;
    logic             err_n;

    // in_ready looks only at the registered count, so space freed by a retire
    // becomes visible one cycle later.
    assign in_ready = occ_cnt < CNT_W'(DEPTH);
    assign valid_o  = occ_cnt != out_cnt;
    assign accept   = in_valid && in_ready;
    assign issue    = valid_o && ready_i && !abort_vld;

    // Order of effects within one cycle: retire, then abort, then accept.
    always_comb begin
        ret_legal = retire_vld && (retire_cnt <= out_cnt);
        ret_a     = ret_ptr;
        out_a     = out_cnt;
        occ_a     = occ_cnt;
        if (ret_legal) begin
            ret_a = PTR_W'(ptr_add(32'(ret_ptr), 32'(retire_cnt), DEPTH));
            out_a = out_cnt - retire_cnt;
            occ_a = occ_cnt - retire_cnt;
        end

        // Abort is judged against the post-retire window; an out-of-range ID is illegal
        abort_d     = CNT_W'(ptr_dist(32'(abort_id), 32'(ret_a), DEPTH));
        abort_legal = abort_vld && in_range(32'(abort_id), DEPTH) && (abort_d < out_a);

        send_n = send_ptr;
        out_n  = out_a;
        if (abort_legal) begin
            // Replayed beats stay in the buffer, so occupancy is untouched
            send_n = abort_id;
            out_n  = abort_d;
        end else if (issue) begin
            send_n = PTR_W'(ptr_inc(32'(send_ptr), DEPTH));
            out_n  = out_a + CNT_W'(1);
        end

        wr_n  = wr_ptr;
        occ_n = occ_a;
        if (accept) begin
            wr_n  = PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
            occ_n = occ_a + CNT_W'(1);
        end

        err_n = (retire_vld && !ret_legal) || (abort_vld && !abort_legal);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            send_ptr <= '0;
            ret_ptr  <= '0;
            out_cnt  <= '0;
            occ_cnt  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr   <= wr_n;
            send_ptr <= send_n;
            ret_ptr  <= ret_a;
            out_cnt  <= out_n;
            occ_cnt  <= occ_n;
            err_q    <= err_n;
        end
    end

    data_manager_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (send_ptr),
        .rdata (data_o)
    );

    assign data_id         = send_ptr;
    assign outstanding_cnt = out_cnt;
    assign occupancy_cnt   = occ_cnt;
    assign err_o           = err_q;

endmodule
